// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct, single-cycle ops register in one cycle,
// MUL runs an iterative shift-add over WIDTH cycles while busy_o stalls issue.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_MUL = 6'b011000;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] mcand, mcand_n, mplier, mplier_n, acc, acc_n, acc_step;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data_n, alu_res;
  logic             zero_n, done_n, err_n, busy_n, alu_err, is_mul;

  // Combinational decode of the single-cycle ops; MUL is flagged separately.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    is_mul  = 1'b0;
    if (!ALUOp_i[1]) begin
      alu_res = ALUOp_i[0] ? (data1_i - data2_i) : (data1_i + data2_i);
    end else begin
      case (funct_i)
        F_ADD:   alu_res = data1_i + data2_i;
        F_SUB:   alu_res = data1_i - data2_i;
        F_AND:   alu_res = data1_i & data2_i;
        F_OR:    alu_res = data1_i | data2_i;
        F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
        F_MUL:   is_mul  = 1'b1;
        default: alu_err = 1'b1;
      endcase
    end
  end

  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    data_n   = data_o;
    zero_n   = zero_o;
    err_n    = err_o;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (is_mul) begin
            mcand_n  = data1_i;
            mplier_n = data2_i;
            acc_n    = '0;
            cnt_n    = CW'(WIDTH);
            state_n  = MUL;
          end else begin
            data_n = alu_res;
            zero_n = (alu_res == '0);
            err_n  = alu_err;
            done_n = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n    = acc_step;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt - CW'(1);
        // Last iteration publishes the sum including this cycle's partial product.
        if (cnt == CW'(1)) begin
          data_n  = acc_step;
          zero_n  = (acc_step == '0);
          err_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == MUL);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      data_o <= '0;
      zero_o <= 1'b1;
      done_o <= 1'b0;
      err_o  <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      data_o <= data_n;
      zero_o <= zero_n;
      done_o <= done_n;
      err_o  <= err_n;
      busy_o <= busy_n;
    end
  end

endmodule
